reg_pla: RTL
============

Name: reg_pla

Overview:
Parametrised, field-programmable registered PLA. It is the programmable successor to the fixed 4-input/5-output PAL logic block.
- AND plane of N_PT product terms over the inputs plus macrocell feedback.
- OR plane per output, feeding a macrocell with mode and polarity control.
- Programmed at runtime through a double-buffered config port with atomic commit. Used as a glue-logic and small-FSM engine.

Parameters:
N_IN, 4, number of external inputs
N_OUT, 5, number of outputs/macrocells
N_PT, 8, number of product terms
(localparam) N_SIG = N_IN+N_OUT; CFG_W = max(2*N_SIG, N_PT+2); AW = clog2(N_PT+N_OUT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in  in  N_IN  logic inputs
en  in  1  macrocell flop clock enable
cfg_valid  in  1  config write request
cfg_ready  out  1  config port can accept a write
cfg_addr  in  AW  row address
cfg_wdata  in  CFG_W  row data
cfg_commit  in  1  copy shadow config to active (pulse)
cfg_err  out  1  one-cycle pulse: write to invalid address
out  out  N_OUT  logic outputs
cfg_rdata  out  CFG_W  active-row readback (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low. Reset clears shadow config, active config and macrocell flops, and puts the FSM in IDLE. Reset values: out=0, cfg_ready=1, cfg_err=0, cfg_rdata=0.
- Signal index s: s<N_IN is in[s]; s>=N_IN is fb[s-N_IN], the Q of macrocell s-N_IN.
  - Feedback always comes from the flop, never from a combinational output, so no comb loops are possible.
- AND row p (addr p, p<N_PT):
  - Bit 2s set: include true literal of signal s. Bit 2s+1 set: include its complement.
  - PT = AND of selected literals.
  - A row with no bits set is disabled: PT=0.
- OR/macrocell row j (addr N_PT+j):
  - Bits [N_PT-1:0] select PTs.
  - Bit N_PT = reg_mode.
  - Bit N_PT+1 = invert.
  - sum_j = OR of selected PTs; none selected gives 0.
  - d_j = sum_j XOR invert.
- Macrocell flop: Q_j <= d_j on each clk edge with en=1; holds when en=0.
  - out[j] = reg_mode ? Q_j : d_j.
  - Comb mode has zero latency. Reg mode has 1-cycle latency.
  - The flop runs in both modes.
- Unused high bits of cfg_wdata are ignored.
- Config FSM:
  - IDLE: cfg_ready=1. On cfg_valid, the row is written into shadow at the edge.
    - addr >= N_PT+N_OUT: write dropped, cfg_err=1 next cycle.
    - cfg_commit sampled at edge k moves the FSM to COMMIT. A write in the same cycle as the commit is included in it.
  - COMMIT (one cycle): cfg_ready=0, writes are not accepted. At edge k+1, active <= shadow in a single cycle, then the FSM returns to IDLE.
  - cfg_commit while in COMMIT is ignored.
- Outputs use the new config from the cycle after edge k+1. Flop state is preserved across a commit.
- Shadow writes without a commit never affect out.
- Reset mid-COMMIT: active config is zero and the commit is lost.

Optional Feature:
PLA_READBACK_EN:
- Defined: cfg_rdata is registered and updated at every clk edge. It holds the active row at cfg_addr, or 0 when cfg_addr is invalid, giving 1-cycle read latency.
- Undefined: cfg_rdata is tied to 0 and no readback mux is built.

Decomposition:
- Package pla_pkg holds:
  - fuse layout helpers: true_bit(s)=2s, comp_bit(s)=2s+1, REG_BIT, INV_BIT offsets;
  - FSM state enum {IDLE, COMMIT};
  - CFG_W/AW computation functions.
- Sub-module pla_macrocell (one per output) holds the OR reduction, XOR polarity, flop with en, and output mux.

Test Plan:
All values use defaults (N_IN=4, N_OUT=5, N_PT=8).
- Reset: assert rst_n=0 asynchronously mid-cycle -> out=0 and cfg_ready=1 immediately; all in values give out=0.
- Comb AND/OR: row0=0x005, row8=0x001, commit; sweep in=0..15 -> out[0]=1 only for in=3,7,11,15, same cycle.
- Invert: add row9=0x201, commit -> out[1] = ~out[0] for all 16 inputs.
- Toggle FSM on out[2], with fb2 = s6 (bits 12/13):
  - Program row1=0x2001, row2=0x1002, row10=0x106, then commit.
  - in=1, en=1 -> out[2] goes 0,1,0,1 on successive edges.
  - en=0 or in=0 -> out[2] holds.
- Shadow/commit timing: write row0=0x0AA without commit -> out unchanged. Assert cfg_commit at edge k -> cfg_ready=0 in cycle k+1, new logic visible after edge k+1. A write in the commit cycle is included.
- Errors: write addr 13 -> cfg_err pulses one cycle and config is unchanged. Reset during COMMIT -> out=0, active config all zero.

Source files
------------

// File: rtl/pla_pkg.sv
// Shared definitions for the registered PLA: fuse layout helpers,
// config FSM states and derived-width functions.
package pla_pkg;

  // Config port FSM: accept writes, or spend one cycle copying shadow to active
  typedef enum logic {IDLE, COMMIT} cfg_state_e;

  // Macrocell control bits sit directly above the N_PT product-term selects
  localparam int REG_OFS = 0;
  localparam int INV_OFS = 1;

  // AND-row fuse for the true literal of signal s
  function automatic int true_bit(input int s);
    return 2 * s;
  endfunction

  // AND-row fuse for the complement literal of signal s
  function automatic int comp_bit(input int s);
    return 2 * s + 1;
  endfunction

  // Row width must hold either an AND row or an OR/macrocell row
  function automatic int cfg_w(input int n_sig, input int n_pt);
    return (2 * n_sig > n_pt + 2) ? 2 * n_sig : n_pt + 2;
  endfunction

  // Address width covering N_PT AND rows plus N_OUT macrocell rows
  function automatic int addr_w(input int n_rows);
    return (n_rows > 1) ? $clog2(n_rows) : 1;
  endfunction

endpackage

// File: rtl/pla_macrocell.sv
// One PLA output: OR of selected product terms, polarity XOR,
// enabled flop (always clocked) and comb/registered output select.
module pla_macrocell #(
  parameter int N_PT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_PT-1:0] pt,
  input  logic [N_PT-1:0] pt_sel,
  input  logic            reg_mode,
  input  logic            invert,
  output logic            out,
  output logic            q
);

  logic d;
  logic q_d, q_q;

  // Sum of selected terms with optional inversion; flop loads only on en
  always_comb begin
    d   = (|(pt & pt_sel)) ^ invert;
    q_d = en ? d : q_q;
  end

  // Macrocell state flop; runs in comb mode too so feedback stays valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q   = q_q;
  assign out = reg_mode ? q_q : d;

endmodule

// File: rtl/reg_pla.sv
// Field-programmable registered PLA. AND plane over inputs plus macrocell
// feedback, one OR/macrocell row per output, double-buffered config with
// a one-cycle atomic commit.
// Build option: define PLA_READBACK_EN to get a registered readback of the
// active row at cfg_addr on cfg_rdata; otherwise cfg_rdata is tied to 0.
module reg_pla
  import pla_pkg::*;
#(
  parameter  int N_IN  = 4,
  parameter  int N_OUT = 5,
  parameter  int N_PT  = 8,
  localparam int N_SIG = N_IN + N_OUT,
  localparam int CFG_W = cfg_w(N_SIG, N_PT),
  localparam int AW    = addr_w(N_PT + N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [CFG_W-1:0] cfg_wdata,
  input  logic             cfg_commit,
  output logic             cfg_err,
  output logic [N_OUT-1:0] out,
  output logic [CFG_W-1:0] cfg_rdata
);

  localparam int            N_ROWS   = N_PT + N_OUT;
  localparam logic [AW:0]   N_ROWS_W = N_ROWS[AW:0];
  localparam int            REG_BIT  = N_PT + REG_OFS;
  localparam int            INV_BIT  = N_PT + INV_OFS;

  typedef struct packed {
    logic             valid;
    logic             commit;
    logic [AW-1:0]    addr;
    logic [CFG_W-1:0] wdata;
  } cfg_req_t;

  cfg_req_t req;
  assign req = {cfg_valid, cfg_commit, cfg_addr, cfg_wdata};

  cfg_state_e                       state_d, state_q;
  logic [N_ROWS-1:0][CFG_W-1:0]     shadow_d, shadow_q;
  logic [N_ROWS-1:0][CFG_W-1:0]     active_d, active_q;
  logic                             err_d, err_q;
  logic                             addr_ok;

  logic [N_OUT-1:0]                 fb;
  logic [N_SIG-1:0]                 sig;
  logic [N_PT-1:0]                  pt;

  assign addr_ok   = ({1'b0, req.addr} < N_ROWS_W);
  assign cfg_ready = (state_q == IDLE);
  assign cfg_err   = err_q;

  // Config FSM: shadow writes and commit request in IDLE, copy in COMMIT
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.valid) begin
          if (addr_ok) shadow_d[req.addr] = req.wdata;
          else         err_d = 1'b1;
        end
        if (req.commit) state_d = COMMIT;
      end
      COMMIT: begin
        active_d = shadow_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config storage and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  // Feedback is taken from macrocell flops only, so no comb loop can form
  assign sig = {fb, in};

  // AND plane: a row with no fuses set is disabled rather than constant 1
  always_comb begin
    pt = '0;
    for (int p = 0; p < N_PT; p++) begin
      pt[p] = |active_q[p][2*N_SIG-1:0];
      for (int s = 0; s < N_SIG; s++) begin
        if (active_q[p][true_bit(s)] && !sig[s]) pt[p] = 1'b0;
        if (active_q[p][comp_bit(s)] &&  sig[s]) pt[p] = 1'b0;
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_mc
    pla_macrocell #(.N_PT(N_PT)) u_mc (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .pt       (pt),
      .pt_sel   (active_q[N_PT+j][N_PT-1:0]),
      .reg_mode (active_q[N_PT+j][REG_BIT]),
      .invert   (active_q[N_PT+j][INV_BIT]),
      .out      (out[j]),
      .q        (fb[j])
    );
  end

  // Fuses above each row's meaningful field are stored but have no function
  logic unused_active;
  assign unused_active = ^active_q;

`ifdef PLA_READBACK_EN
  logic [CFG_W-1:0] rdata_d, rdata_q;

  // Readback mux of the active row; invalid addresses read as zero
  always_comb begin
    rdata_d = '0;
    if (addr_ok) rdata_d = active_q[req.addr];
  end

  // One-cycle registered readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign cfg_rdata = rdata_q;
`else
  assign cfg_rdata = '0;
`endif

endmodule
